// File: rtl/floppy_write_decoder.sv
// floppy_write_decoder: turns the GCR nibble stream the IWM writes into Mac
// 6-and-2 sector data bytes for the floppy track buffer.
module floppy_write_decoder #(
   parameter int TAG_BYTES = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] nibble_in,
   input  logic       nibble_strobe,
   input  logic [3:0] spt,
   output logic [7:0] writeDataDecoded,
   output logic [8:0] writeAddr,
   output logic [3:0] writeSector,
   output logic       writeStrobe,
   output logic       sector_done,
   output logic       write_error
);

   typedef enum logic [2:0] {
      ST_HUNT  = 3'd0,
      ST_SECT  = 3'd1,
      ST_DATA  = 3'd2,
      ST_EMIT  = 3'd3,
      ST_CKSUM = 3'd4,
      ST_SLIP  = 3'd5
   } state_t;

   localparam logic [9:0] TAG_N       = 10'(TAG_BYTES);
   localparam logic [7:0] LAST_GROUP  = 8'd174;
   localparam logic [7:0] CKSUM_PHASE = 8'd175;

   // Apple 6-and-2 GCR: bit 6 of the result flags a legal nibble, bits 5:0 its value.
   function automatic logic [6:0] gcr_decode(input logic [7:0] nib);
      logic [6:0] r;
      case (nib)
         8'h96: r = 7'h40;  8'h97: r = 7'h41;  8'h9A: r = 7'h42;  8'h9B: r = 7'h43;
         8'h9D: r = 7'h44;  8'h9E: r = 7'h45;  8'h9F: r = 7'h46;  8'hA6: r = 7'h47;
         8'hA7: r = 7'h48;  8'hAB: r = 7'h49;  8'hAC: r = 7'h4A;  8'hAD: r = 7'h4B;
         8'hAE: r = 7'h4C;  8'hAF: r = 7'h4D;  8'hB2: r = 7'h4E;  8'hB3: r = 7'h4F;
         8'hB4: r = 7'h50;  8'hB5: r = 7'h51;  8'hB6: r = 7'h52;  8'hB7: r = 7'h53;
         8'hB9: r = 7'h54;  8'hBA: r = 7'h55;  8'hBB: r = 7'h56;  8'hBC: r = 7'h57;
         8'hBD: r = 7'h58;  8'hBE: r = 7'h59;  8'hBF: r = 7'h5A;  8'hCB: r = 7'h5B;
         8'hCD: r = 7'h5C;  8'hCE: r = 7'h5D;  8'hCF: r = 7'h5E;  8'hD3: r = 7'h5F;
         8'hD6: r = 7'h60;  8'hD7: r = 7'h61;  8'hD9: r = 7'h62;  8'hDA: r = 7'h63;
         8'hDB: r = 7'h64;  8'hDC: r = 7'h65;  8'hDD: r = 7'h66;  8'hDE: r = 7'h67;
         8'hDF: r = 7'h68;  8'hE5: r = 7'h69;  8'hE6: r = 7'h6A;  8'hE7: r = 7'h6B;
         8'hE9: r = 7'h6C;  8'hEA: r = 7'h6D;  8'hEB: r = 7'h6E;  8'hEC: r = 7'h6F;
         8'hED: r = 7'h70;  8'hEE: r = 7'h71;  8'hEF: r = 7'h72;  8'hF2: r = 7'h73;
         8'hF3: r = 7'h74;  8'hF4: r = 7'h75;  8'hF5: r = 7'h76;  8'hF6: r = 7'h77;
         8'hF7: r = 7'h78;  8'hF9: r = 7'h79;  8'hFA: r = 7'h7A;  8'hFB: r = 7'h7B;
         8'hFC: r = 7'h7C;  8'hFD: r = 7'h7D;  8'hFE: r = 7'h7E;  8'hFF: r = 7'h7F;
         default: r = 7'h00;
      endcase
      return r;
   endfunction

   state_t      state_r, state_next_s, phase_s;
   logic [15:0] shift_r;
   logic [1:0]  nib_idx_r;
   logic [7:0]  group_r;
   logic [5:0]  top_r;
   logic [7:0]  hold_a_r, hold_b_r;
   logic [8:0]  c1_r, c2_r, c3_r;
   logic [9:0]  n_r;
   logic        em_busy_r, em_phase_r, em_pend_r;
   logic [1:0]  em_idx_r, em_last_r;
   logic [7:0]  em_a_r, em_b_r, em_c_r;

   logic [6:0]  dec_s;
   logic        nib_ok_s;
   logic [5:0]  nib_val_s;
   logic        sync_s, group_end_s, cks_ok_s;
   logic        data_nib_s, cks_nib_s, slip_nib_s, launch_s;
   logic        set_err_s, prologue_s, sect_ok_s, done_s;
   logic [7:0]  v_s;
   logic [8:0]  c1_rot_s, c1_next_s, c2_next_s, c3_next_s;

   assign dec_s       = gcr_decode(nibble_in);
   assign nib_ok_s    = dec_s[6];
   assign nib_val_s   = dec_s[5:0];
   assign sync_s      = ({shift_r, nibble_in} == 24'hD5AAAD);
   assign group_end_s = (nib_idx_r == 2'd3) ||
                        ((nib_idx_r == 2'd2) && (group_r == LAST_GROUP));
   assign cks_ok_s    = (hold_a_r == c1_r[7:0]) && (hold_b_r == c2_r[7:0]) &&
                        ({top_r[1:0], nib_val_s} == c3_r[7:0]);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_HUNT;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next state and per-nibble control; EMIT forwards an early nibble to the state it returns to
   always_comb begin
      state_next_s = state_r;
      phase_s      = state_r;
      data_nib_s   = 1'b0;
      cks_nib_s    = 1'b0;
      slip_nib_s   = 1'b0;
      launch_s     = 1'b0;
      set_err_s    = 1'b0;
      prologue_s   = 1'b0;
      sect_ok_s    = 1'b0;
      done_s       = 1'b0;
      if (state_r == ST_EMIT) begin
         phase_s = (group_r == CKSUM_PHASE) ? ST_CKSUM : ST_DATA;
         if (!em_busy_r) begin
            state_next_s = phase_s;
         end else begin
            state_next_s = ST_EMIT;
         end
      end else begin
         phase_s = state_r;
      end
      if (nibble_strobe) begin
         case (phase_s)
            ST_HUNT: begin
               if (sync_s) begin
                  prologue_s   = 1'b1;
                  state_next_s = ST_SECT;
               end else begin
                  state_next_s = ST_HUNT;
               end
            end
            ST_SECT: begin
               if (nib_ok_s && ({2'b00, spt} > nib_val_s)) begin
                  sect_ok_s    = 1'b1;
                  state_next_s = ST_DATA;
               end else begin
                  set_err_s    = 1'b1;
                  state_next_s = ST_HUNT;
               end
            end
            ST_DATA: begin
               if (!nib_ok_s) begin
                  set_err_s    = 1'b1;
                  state_next_s = ST_HUNT;
               end else begin
                  data_nib_s = 1'b1;
                  if (group_end_s) begin
                     launch_s     = 1'b1;
                     state_next_s = ST_EMIT;
                  end else begin
                     state_next_s = ST_DATA;
                  end
               end
            end
            ST_CKSUM: begin
               if (!nib_ok_s) begin
                  set_err_s    = 1'b1;
                  state_next_s = ST_HUNT;
               end else begin
                  cks_nib_s = 1'b1;
                  if (nib_idx_r == 2'd3) begin
                     set_err_s    = !cks_ok_s;
                     state_next_s = ST_SLIP;
                  end else begin
                     state_next_s = ST_CKSUM;
                  end
               end
            end
            ST_SLIP: begin
               slip_nib_s = 1'b1;
               if (nib_idx_r == 2'd0) begin
                  set_err_s    = (nibble_in != 8'hDE);
                  state_next_s = ST_SLIP;
               end else begin
                  set_err_s    = (nibble_in != 8'hAA);
                  done_s       = 1'b1;
                  state_next_s = ST_HUNT;
               end
            end
            default: begin
               state_next_s = ST_HUNT;
            end
         endcase
      end else begin
         data_nib_s = 1'b0;
      end
   end

   // Nibble capture: sync shift register, group assembly and sector latch
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_r     <= 16'h0000;
         nib_idx_r   <= 2'd0;
         group_r     <= 8'd0;
         top_r       <= 6'd0;
         hold_a_r    <= 8'h00;
         hold_b_r    <= 8'h00;
         writeSector <= 4'd0;
      end else begin
         if (nibble_strobe) begin
            shift_r <= {shift_r[7:0], nibble_in};
         end
         if (prologue_s || sect_ok_s || done_s) begin
            nib_idx_r <= 2'd0;
            group_r   <= 8'd0;
         end else if (data_nib_s || cks_nib_s || slip_nib_s) begin
            nib_idx_r <= launch_s ? 2'd0 : nib_idx_r + 2'd1;
            if (launch_s) begin
               group_r <= group_r + 8'd1;
            end
            case (nib_idx_r)
               2'd0:    top_r    <= nib_val_s;
               2'd1:    hold_a_r <= {top_r[5:4], nib_val_s};
               2'd2:    hold_b_r <= {top_r[3:2], nib_val_s};
               default: top_r    <= top_r;
            endcase
         end
         if (sect_ok_s) begin
            writeSector <= nib_val_s[3:0];
         end
      end
   end

   // Byte descramble and next checksum values for the byte being emitted
   always_comb begin
      c1_rot_s  = {c1_r[7], c1_r[6:0], c1_r[7]};
      c1_next_s = c1_r;
      c2_next_s = c2_r;
      c3_next_s = c3_r;
      v_s       = 8'h00;
      case (em_idx_r)
         2'd0: begin
            v_s       = em_a_r ^ c1_rot_s[7:0];
            c1_next_s = {1'b0, c1_rot_s[7:0]};
            c3_next_s = c3_r + {1'b0, v_s} + {8'h00, c1_rot_s[8]};
         end
         2'd1: begin
            v_s       = em_b_r ^ c3_r[7:0];
            c2_next_s = c2_r + {1'b0, v_s} + {8'h00, c3_r[8]};
            c3_next_s = {1'b0, c3_r[7:0]};
         end
         2'd2: begin
            v_s       = em_c_r ^ c2_r[7:0];
            c1_next_s = c1_r + {1'b0, v_s} + {8'h00, c2_r[8]};
            c2_next_s = {1'b0, c2_r[7:0]};
         end
         default: begin
            v_s = 8'h00;
         end
      endcase
   end

   // Emitter: first clock of a byte presents data/addr, second clock toggles the strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         em_busy_r        <= 1'b0;
         em_phase_r       <= 1'b0;
         em_pend_r        <= 1'b0;
         em_idx_r         <= 2'd0;
         em_last_r        <= 2'd0;
         em_a_r           <= 8'h00;
         em_b_r           <= 8'h00;
         em_c_r           <= 8'h00;
         writeDataDecoded <= 8'h00;
         writeAddr        <= 9'd0;
         writeStrobe      <= 1'b0;
      end else if (launch_s) begin
         em_busy_r  <= 1'b1;
         em_phase_r <= 1'b0;
         em_pend_r  <= 1'b0;
         em_idx_r   <= 2'd0;
         em_last_r  <= (group_r == LAST_GROUP) ? 2'd1 : 2'd2;
         em_a_r     <= hold_a_r;
         em_b_r     <= (group_r == LAST_GROUP) ? {top_r[3:2], nib_val_s} : hold_b_r;
         em_c_r     <= {top_r[1:0], nib_val_s};
      end else if (em_busy_r) begin
         em_phase_r <= ~em_phase_r;
         if (!em_phase_r) begin
            em_pend_r <= (n_r >= TAG_N);
            if (n_r >= TAG_N) begin
               writeDataDecoded <= v_s;
               writeAddr        <= n_r[8:0] - TAG_N[8:0];
            end
         end else begin
            if (em_pend_r) begin
               writeStrobe <= ~writeStrobe;
            end
            if (em_idx_r == em_last_r) begin
               em_busy_r <= 1'b0;
            end else begin
               em_idx_r <= em_idx_r + 2'd1;
            end
         end
      end
   end

   // Running checksums and decoded-byte counter
   always_ff @(posedge clk) begin
      if (rst || prologue_s) begin
         c1_r <= 9'd0;
         c2_r <= 9'd0;
         c3_r <= 9'd0;
         n_r  <= 10'd0;
      end else if (em_busy_r && !em_phase_r && !launch_s) begin
         c1_r <= c1_next_s;
         c2_r <= c2_next_s;
         c3_r <= c3_next_s;
         n_r  <= n_r + 10'd1;
      end
   end

   // Field status: sector_done pulse and sticky error cleared by the next prologue
   always_ff @(posedge clk) begin
      if (rst) begin
         sector_done <= 1'b0;
         write_error <= 1'b0;
      end else begin
         sector_done <= done_s;
         if (prologue_s) begin
            write_error <= 1'b0;
         end else if (set_err_s) begin
            write_error <= 1'b1;
         end
      end
   end

endmodule

// File: doc/floppy_write_decoder.md
Name: floppy_write_decoder

Overview:
Decodes the GCR nibble stream written by the IWM during floppy write operations into sector data bytes. It feeds the floppy track buffer through the writeDataDecoded/writeAddr/writeSector/writeStrobe interface. It hunts for the Mac data-field prologue, decodes the 6-and-2 GCR payload, removes the Sony checksum scrambling and drops the 12 tag bytes. It emits the 512 data bytes with sector-relative addresses and flags checksum or format errors.

Parameters:
TAG_BYTES, 12, decoded bytes at the start of each data field that are discarded and not emitted.

Ports:
clk  in  1  system clock
rst  in  1  reset
nibble_in  in  8  GCR nibble written by the IWM
nibble_strobe  in  1  one-cycle pulse; nibble_in is valid on this cycle
spt  in  4  sectors per track of the current track
writeDataDecoded  out  8  decoded data byte
writeAddr  out  9  byte index 0..511 within the sector
writeSector  out  4  sector number from the data field
writeStrobe  out  1  toggles once per emitted byte
sector_done  out  1  one-cycle pulse when a data field completes
write_error  out  1  sticky error flag, cleared on the next prologue

Behaviour:
- Reset is rst, synchronous, active-high; the clock is clk.
- Reset values: all outputs are 0; the FSM is in HUNT; checksums and counters are 0.
- Only nibble_strobe cycles advance the FSM. The emission substate runs autonomously.
- GCR translation uses the standard Apple 6-and-2 table: 64 valid nibbles mapping to values 0x00..0x3F.
  - Any other nibble inside SECT, DATA or CKSUM sets write_error and returns the FSM to HUNT.
- States:
  - HUNT: shift register over the last 3 nibbles. On D5 AA AD:
    - clear write_error and c1/c2/c3;
    - set the byte counter to 0;
    - go to SECT.
    - An address field (D5 AA 96) is ignored and the hunt continues.
  - SECT: decode one nibble to value s.
    - If s < spt, latch writeSector = s[3:0] and go to DATA.
    - Otherwise set write_error and go to HUNT.
  - DATA: 699 nibbles arranged as 174 groups of 4 nibbles plus a final group of 3.
    - Nibble 0 of a group holds the top bits: [5:4] → byte A, [3:2] → B, [1:0] → C.
    - Nibbles 1..3 hold the low 6 bits of A, B and C.
    - The final group carries A and B only; C is absent.
    - After each group, go to EMIT, then return to DATA. After the final group, go to CKSUM.
  - EMIT: descramble A, B, C in order, one byte per 2 clocks. All checksums are 9-bit.
    - Byte A: c1 = rotl8(c1[7:0]), with carry-out to bit 0 and bit 8 set to carry. v = A ^ c1[7:0]. c3 = c3 + v + c1[8]. c1[8] = 0.
    - Byte B: v = B ^ c3[7:0]. c2 = c2 + v + c3[8]. c3[8] = 0.
    - Byte C: v = C ^ c2[7:0]. c1 = c1 + v + c2[8]. c2[8] = 0.
    - Emission rule: byte counter n increments for each byte v. If n ≥ TAG_BYTES:
      - writeDataDecoded = v;
      - writeAddr = n − TAG_BYTES;
      - toggle writeStrobe.
    - Data and addr are stable at least 1 clock before each toggle and are held until the next toggle.
  - CKSUM: 4 nibbles give 3 bytes X, Y, Z using the same top-bits layout.
    - Required: X = c1[7:0], Y = c2[7:0], Z = c3[7:0]. A mismatch sets write_error.
    - Go to SLIP.
  - SLIP: expect DE then AA. A mismatch sets write_error.
    - Either way, pulse sector_done and go to HUNT.
- Throughput: nibble_strobe spacing is at least 8 clocks, so EMIT (6 clocks) always completes before the next group starts.
  - A nibble_strobe arriving during EMIT is accepted as the next group's nibble 0.
  - It must not be dropped.
- Exactly 512 strobe toggles per valid field; writeAddr spans 0..511 with no gap or duplicate.
- A prologue seen mid-field does not restart the decode: bytes are not scanned for sync while in DATA.
- An aborted field leaves the already-emitted bytes in the track buffer; write_error reports the failure.
- rst mid-field returns the FSM to HUNT immediately. writeStrobe resets to 0, which can itself count as one toggle downstream.

Test Plan:
- Reset: all outputs are 0 after rst, and a stray nibble 0x96 causes no strobe → pass.
- Valid field: sector 3, spt=12, data bytes i&0xFF, tags 0, correct checksum and slip → 512 toggles, writeAddr 0..511 carrying data 0x00..0xFF twice, writeSector=3, one sector_done, write_error=0.
- Bad checksum: same field with X flipped → 512 toggles, sector_done, write_error=1.
- Sector out of range: sector nibble decoding to 11 with spt=10 → no toggles, write_error=1, FSM in HUNT; the next valid field decodes cleanly and clears the error.
- Invalid nibble 0xAA at DATA nibble 100 → write_error=1, HUNT; toggle count equals bytes emitted before the abort.
- Timing: nibble_strobe spacing exactly 8 clocks and an address field preceding the data field → no dropped bytes, and the address field is ignored.
